// File: rtl/ifetch_pkg.sv
// Purpose : shared types and constants for the instruction fetch stage.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package ifetch_pkg;

  // FETCH: request outstanding at pc.
  // HOLD : word captured, waiting for the pipeline to accept it.
  // FLUSH: redirect pending behind an in-flight request.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_pc_register.sv
// Purpose : 32-bit program counter with synchronous reset, load enable and word alignment.
// Latency : q updates on the rising edge after load=1.
// Backpressure: none; holds its value while load=0.
// Ports   : clk, rst (sync, active-high), load, d (next pc), q (current pc).
module pc_register
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= align_pc(RESET_PC);
    end else if (load) begin
      q <= align_pc(d);
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Purpose : IF stage; owns the PC, fetches from variable-latency imem, applies redirects and stalls.
// Latency : zero-wait memory gives one instruction per cycle; N wait cycles delay the strobe by N.
// Backpressure: PCWrite=0 parks a returned word in HOLD (no request issued) until the pipeline advances.
// Ports   : clk/rst; PCWrite, branchTaken, branchTarget from hazard unit/EX;
//           imemReq/imemAddr/imemReady/imemRdata to instruction memory;
//           instrOut/nextPC/IFIDControl to the IF/ID register.
module instruction_fetch_stage
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrOut,
  output logic [31:0] nextPC,
  output logic        IFIDControl
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic        pc_load;
  logic [31:0] hold_instr;
  logic [31:0] redir_target;
  logic        hold_load;
  logic        redir_load;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_d),
    .q    (pc)
  );

  // The request address is always the architectural pc; in FLUSH this is
  // deliberately the old pc so the outstanding request stays stable.
  assign imemAddr = pc;
  assign nextPC   = pc + PC_STEP;

  always_comb begin
    state_nxt   = state;
    pc_load     = 1'b0;
    pc_d        = pc + PC_STEP;
    hold_load   = 1'b0;
    redir_load  = 1'b0;
    imemReq     = 1'b0;
    IFIDControl = 1'b0;
    instrOut    = INSTR_NOP;

    case (state)
      FETCH: begin
        imemReq = 1'b1;
        if (imemReady) begin
          if (branchTaken) begin
            // Returned word belongs to the wrong path: drop it.
            pc_load = 1'b1;
            pc_d    = branchTarget;
          end else if (PCWrite) begin
            IFIDControl = 1'b1;
            instrOut    = imemRdata;
            pc_load     = 1'b1;
          end else begin
            hold_load = 1'b1;
            state_nxt = HOLD;
          end
        end else if (branchTaken) begin
          // Cannot abandon the in-flight request; remember where to go.
          redir_load = 1'b1;
          state_nxt  = FLUSH;
        end
      end

      HOLD: begin
        if (branchTaken) begin
          pc_load   = 1'b1;
          pc_d      = branchTarget;
          state_nxt = FETCH;
        end else if (PCWrite) begin
          IFIDControl = 1'b1;
          instrOut    = hold_instr;
          pc_load     = 1'b1;
          state_nxt   = FETCH;
        end
      end

      FLUSH: begin
        imemReq = 1'b1;
        if (branchTaken) begin
          redir_load = 1'b1;
        end
        if (imemReady) begin
          // A same-cycle redirect is newer than the stored one.
          pc_load   = 1'b1;
          pc_d      = branchTaken ? branchTarget : redir_target;
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase

    if (rst) begin
      imemReq     = 1'b0;
      IFIDControl = 1'b0;
      instrOut    = INSTR_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      hold_instr   <= INSTR_NOP;
      redir_target <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      if (hold_load) begin
        hold_instr <= imemRdata;
      end
      if (redir_load) begin
        redir_target <= align_pc(branchTarget);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Purpose : directed + randomized bench for instruction_fetch_stage against a program-order model.
// Latency : memory model with programmable or random wait states.
// Backpressure: PCWrite stalls driven from the stimulus sequence.
module tb_instruction_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] instrOut;
  logic [31:0] nextPC;
  logic        IFIDControl;

  int tests = 0;
  int fails = 0;

  instruction_fetch_stage #(
    .RESET_PC (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemReady    (imemReady),
    .imemRdata    (imemRdata),
    .instrOut     (instrOut),
    .nextPC       (nextPC),
    .IFIDControl  (IFIDControl)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct nonzero word per aligned address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hA500_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- instruction memory model ----------------
  int unsigned mem_lat  = 0;
  int unsigned rand_lat = 0;
  bit          mem_rand = 1'b0;
  int unsigned cnt      = 0;
  int unsigned eff_lat;

  assign eff_lat   = mem_rand ? rand_lat : mem_lat;
  assign imemReady = imemReq && (cnt >= eff_lat);
  assign imemRdata = imemReady ? word_at(imemAddr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
    end else if (!imemReq || imemReady) begin
      cnt <= 0;
      if (imemReady) rand_lat <= $urandom_range(0, 3);
    end else begin
      cnt <= cnt + 1;
    end
  end

  // ---------------- program-order scoreboard ----------------
  // Delivered instructions must follow the sequential program order from
  // RESET_PC, restarting at each honoured redirect target.
  logic [31:0] exp_pc    = RESET_PC;
  logic [31:0] prev_addr = 32'h0;
  bit          prev_pend = 1'b0;
  int          deliv     = 0;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      chk("rst_req", {31'b0, imemReq}, 32'd0);
      chk("rst_strobe", {31'b0, IFIDControl}, 32'd0);
      exp_pc = RESET_PC;
    end else begin
      if (prev_pend) begin
        chk("req_held", {31'b0, imemReq}, 32'd1);
        chk("addr_stable", imemAddr, prev_addr);
      end
      if (IFIDControl) begin
        chk("sb_instr", instrOut, word_at(exp_pc));
        chk("sb_nextpc", nextPC, exp_pc + 32'd4);
        chk("strobe_qual", {31'b0, (!branchTaken && PCWrite)}, 32'd1);
        exp_pc = exp_pc + 32'd4;
        deliv++;
      end else begin
        chk("nop_out", instrOut, 32'h0);
      end
      if (branchTaken) exp_pc = branchTarget & ~32'h3;
    end
    prev_pend = !rst && imemReq && !imemReady;
    prev_addr = imemAddr;
  end

  // ---------------- directed + random stimulus ----------------
  task automatic nxt;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [31:0] a, input int budget);
    bit hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      if (imemReq && imemAddr == a) hit = 1'b1;
      else nxt();
    end
    chk("wait_addr_reached", {31'b0, hit}, 32'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; PCWrite = 1'b1; branchTaken = 1'b0; branchTarget = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req", {31'b0, imemReq}, 32'd0);
    chk("reset_strobe", {31'b0, IFIDControl}, 32'd0);
    chk("reset_instr", instrOut, 32'h0);
    chk("reset_addr", imemAddr, RESET_PC);

    // Zero-wait streaming from reset.
    nxt(); rst = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("stream_addr", imemAddr, 32'(4 * i));
      chk("stream_strobe", {31'b0, IFIDControl}, 32'd1);
      chk("stream_nextpc", nextPC, 32'(4 * i + 4));
      nxt();
    end

    // Stall while the word at 0x10 arrives.
    PCWrite = 1'b0; #1;
    chk("stall_addr", imemAddr, 32'h10);
    chk("stall_no_pulse", {31'b0, IFIDControl}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      nxt();
      chk("hold_req", {31'b0, imemReq}, 32'd0);
      chk("hold_no_pulse", {31'b0, IFIDControl}, 32'd0);
    end
    nxt(); PCWrite = 1'b1; #1;
    chk("release_pulse", {31'b0, IFIDControl}, 32'd1);
    chk("release_instr", instrOut, word_at(32'h10));
    chk("release_nextpc", nextPC, 32'h14);
    nxt();
    chk("after_hold_addr", imemAddr, 32'h14);
    chk("after_hold_req", {31'b0, imemReq}, 32'd1);

    // Two wait states: pulse on every third cycle.
    mem_lat = 2; #1;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        chk("wait2_addr", imemAddr, 32'(32'h14 + 4 * r));
        chk("wait2_strobe", {31'b0, IFIDControl}, {31'b0, k == 2});
        nxt();
      end
    end

    // Redirect behind a 3-wait fetch at 0x20.
    mem_lat = 3; #1;
    wait_addr(32'h20, 12);
    branchTaken = 1'b1; branchTarget = 32'h103; #1;
    chk("redir_no_pulse", {31'b0, IFIDControl}, 32'd0);
    nxt(); branchTaken = 1'b0; #1;
    chk("flush_req", {31'b0, imemReq}, 32'd1);
    chk("flush_addr", imemAddr, 32'h20);
    wait_addr(32'h100, 8);

    // Coincident ready, branch and stall.
    mem_lat = 0; branchTaken = 1'b1; branchTarget = 32'h40; PCWrite = 1'b0; #1;
    chk("coinc_ready", {31'b0, imemReady}, 32'd1);
    chk("coinc_no_pulse", {31'b0, IFIDControl}, 32'd0);
    nxt(); branchTaken = 1'b0; PCWrite = 1'b1; #1;
    chk("coinc_addr", imemAddr, 32'h40);

    // Reset while in FLUSH.
    mem_lat = 3; branchTaken = 1'b1; branchTarget = 32'h200; #1;
    chk("flushrst_not_ready", {31'b0, imemReady}, 32'd0);
    nxt(); branchTaken = 1'b0; rst = 1'b1; #1;
    chk("flushrst_req", {31'b0, imemReq}, 32'd0);
    nxt();
    chk("flushrst_req2", {31'b0, imemReq}, 32'd0);
    chk("flushrst_addr", imemAddr, RESET_PC);
    nxt(); rst = 1'b0; mem_lat = 0; #1;
    chk("postrst_addr", imemAddr, RESET_PC);
    chk("postrst_strobe", {31'b0, IFIDControl}, 32'd1);
    nxt();
    chk("postrst_addr2", imemAddr, RESET_PC + 32'd4);
    nxt();

    // PC wrap.
    branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFF; #1;
    chk("wrap_branch_no_pulse", {31'b0, IFIDControl}, 32'd0);
    nxt(); branchTaken = 1'b0; #1;
    chk("wrap_addr", imemAddr, 32'hFFFF_FFFC);
    chk("wrap_strobe", {31'b0, IFIDControl}, 32'd1);
    chk("wrap_nextpc", nextPC, 32'h0);
    nxt();
    chk("wrap_next_addr", imemAddr, 32'h0);

    // Randomized traffic; the scoreboard checks every cycle.
    mem_rand = 1'b1;
    d0 = deliv;
    for (int c = 0; c < 800; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      PCWrite      = ($urandom_range(0, 3) != 0);
      branchTaken  = ($urandom_range(0, 9) == 0);
      branchTarget = $urandom;
      nxt();
    end
    rst = 1'b0; PCWrite = 1'b1; branchTaken = 1'b0;
    chk("rand_progress", {31'b0, (deliv - d0) > 50}, 32'd1);
    nxt();
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register. Owns the PC, issues requests to a variable-latency instruction memory, applies branch/jump redirects from EX and stalls from the hazard unit. Delivers `instrOut`/`nextPC` with a one-cycle write strobe `IFIDControl` that the IF/ID register samples on the next `posedge clk`.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PCWrite`  in  1  hazard unit: 1 = pipeline may advance; 0 = stall IF.
- `branchTaken`  in  1  EX-stage redirect request, single-cycle qualifier.
- `branchTarget`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `imemReq`  out  1  instruction memory request.
- `imemAddr`  out  32  request address, equal to the current PC.
- `imemReady`  in  1  memory response valid; asserted only while `imemReq`=1.
- `imemRdata`  in  32  instruction word, valid when `imemReady`=1.
- `instrOut`  out  32  instruction to IF/ID; 32'h0000_0000 (NOP) whenever `IFIDControl`=0.
- `nextPC`  out  32  PC+4 of the delivered instruction, to IF/ID.
- `IFIDControl`  out  1  IF/ID write enable, one pulse per delivered instruction.

## Operation
- Registers: `pc`, `state`, `holdInstr`, `redirTarget`.
- Memory contract: single outstanding request; `imemReq` and `imemAddr` are held stable until `imemReady`. Zero-wait responses (ready in the request cycle) are legal.
- FETCH: `imemReq`=1, `imemAddr`=`pc`.
  - `imemReady` & `branchTaken`: data discarded, `pc`<=target, stay FETCH, `IFIDControl`=0.
  - `imemReady` & `PCWrite`: `IFIDControl`=1, `instrOut`=`imemRdata`, `pc`<=`pc`+4, stay FETCH.
  - `imemReady` & !`PCWrite`: `holdInstr`<=`imemRdata`, go to HOLD.
  - !`imemReady` & `branchTaken`: `redirTarget`<=target, go to FLUSH.
- HOLD: `imemReq`=0.
  - `branchTaken`: held word discarded, `pc`<=target, go to FETCH. Branch has priority over `PCWrite`.
  - `PCWrite`: `IFIDControl`=1, `instrOut`=`holdInstr`, `pc`<=`pc`+4, go to FETCH.
- FLUSH: `imemReq`=1 at the old `pc`. A further `branchTaken` overwrites `redirTarget` (latest wins). On `imemReady`: data discarded, `pc`<=`redirTarget` (or the same-cycle `branchTarget` if `branchTaken`), go to FETCH.
- Priority when events coincide: `rst` > `branchTaken` > `PCWrite`.
- `branchTaken` is honoured in every state regardless of `PCWrite`.
- `nextPC` = `pc`+4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).

## Timing
- Reset (`rst`=1 at an edge): `pc`<=`RESET_PC`, state<=FETCH, `holdInstr`<=0, `redirTarget`<=0.
- While `rst`=1: `imemReq`=0, `IFIDControl`=0, `instrOut`=0, `imemAddr`=`pc`.
- The first request is issued in the cycle after `rst` deasserts, at `RESET_PC`.
- Reset mid-request abandons the request. Instruction memory is reset by the same `rst`.
- Outputs are combinational from state, `pc`, `holdInstr` and `imemRdata`. IF/ID captures them at the edge ending the strobe cycle.
- Latency: with zero-wait memory and no stalls, one instruction per cycle, and `IFIDControl` stays high continuously. With N wait cycles, the pulse comes N cycles after the request.
- A redirect costs at least one bubble; each cycle spent in FLUSH adds one more bubble.
- `IFIDControl` is never asserted in a cycle with `branchTaken`=1 or `PCWrite`=0.

## Structure
- Package `ifetch_pkg`:
  - state enum {FETCH, HOLD, FLUSH};
  - `INSTR_NOP`=32'h0000_0000;
  - `PC_STEP`=32'd4.
- One sub-module is natural: `pc_register`, a 32-bit register with synchronous reset to `RESET_PC`, load enable and alignment masking.
- The FSM and output multiplexing stay in the top module.

## Test plan
- Reset release, zero-wait memory returning word = address: `imemAddr` 0, 4, 8, 12 on consecutive cycles; `IFIDControl` high every cycle; `nextPC` 4, 8, 12, 16.
- 2-wait memory, no stalls: `IFIDControl` pulses every 3rd cycle; each pulse carries the matching word; `imemAddr` is stable for all 3 cycles of each request.
- Stall: `PCWrite`=0 for 3 cycles as the word at 0x10 arrives → HOLD, `imemReq`=0, no pulse. On `PCWrite`=1: one pulse with the 0x10 word and `nextPC`=0x14, then a fetch at 0x14.
- Redirect during a 3-wait fetch at 0x20 with `branchTarget`=0x103: FLUSH, old data dropped, next request at 0x100, and no pulse carries the 0x20 word.
- Coincident `imemReady`, `branchTaken` (target 0x40) and `PCWrite`=0: no pulse; next `imemAddr`=0x40.
- `rst` asserted while in FLUSH: next cycle `imemReq`=0; after release, fetch at `RESET_PC`; the stale `redirTarget` is never used. Separately, PC wrap from 0xFFFF_FFFC gives `nextPC`=0.
